// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default sizing for the fetch sequencer.
package fetch_sequencer_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 4;
    localparam int MEM_LAT_DEF   = 1;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_RUN     = 2'd1,
        FS_MEMWAIT = 2'd2,
        FS_DONE    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control-in / PC-out bundle between Ctrl, the LUT config path and the sequencer.
interface fetch_sequencer_if #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4
);
    logic                 Start;
    logic [PC_W-1:0]      StartAddr;
    logic                 Jump;
    logic                 BranchEn;
    logic                 BranchAccept;
    logic [LUT_IDX_W-1:0] BranchIdx;
    logic                 MemAccess;
    logic                 Halt;
    logic                 LutWe;
    logic [LUT_IDX_W-1:0] LutWaddr;
    logic [PC_W-1:0]      LutWdata;
    logic [PC_W-1:0]      ProgCtr;
    logic                 Commit;
    logic                 Busy;
    logic                 Done;

    modport master (
        output Start, StartAddr, Jump, BranchEn, BranchAccept, BranchIdx,
               MemAccess, Halt, LutWe, LutWaddr, LutWdata,
        input  ProgCtr, Commit, Busy, Done
    );

    modport slave (
        input  Start, StartAddr, Jump, BranchEn, BranchAccept, BranchIdx,
               MemAccess, Halt, LutWe, LutWaddr, LutWdata,
        output ProgCtr, Commit, Busy, Done
    );
endinterface

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch-target table: one synchronous write port, one combinational read port,
// asynchronously cleared. A same-index read during a write sees the old entry.
module branch_lut #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**IDX_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**IDX_W; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: PC, branch LUT and LDR/STR stall FSM.
// Optional FETCH_SEQUENCER_CYCLE_COUNT_EN adds a saturating busy-cycle counter.
//
// state      | meaning
// FS_IDLE    | waiting for Start after reset
// FS_RUN     | one instruction per cycle
// FS_MEMWAIT | stalling a memory instruction; commits when counter reaches 0
// FS_DONE    | halted, PC frozen, Done asserted until next Start
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF,
    parameter int MEM_LAT   = MEM_LAT_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
    output logic [15:0]        CycleCount,
`endif
    fetch_sequencer_if.slave   bus
);
    localparam logic [2:0] LAT_M1 = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] lut_rdata;
    logic            commit;
    logic            take_next;

    branch_lut #(
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_lut (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (bus.LutWe),
        .waddr_i (bus.LutWaddr),
        .wdata_i (bus.LutWdata),
        .raddr_i (bus.BranchIdx),
        .rdata_o (lut_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FS_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        take_next = 1'b0;
        case (state_q)
            FS_IDLE, FS_DONE: begin
                if (bus.Start) begin
                    pc_d    = bus.StartAddr;
                    state_d = FS_RUN;
                end
            end
            FS_RUN: begin
                if (bus.MemAccess && (MEM_LAT > 0)) begin
                    cnt_d   = LAT_M1;
                    state_d = FS_MEMWAIT;
                end else begin
                    commit    = 1'b1;
                    take_next = 1'b1;
                end
            end
            FS_MEMWAIT: begin
                if (cnt_q == 3'd0) begin
                    commit    = 1'b1;
                    take_next = 1'b1;
                    state_d   = FS_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = FS_IDLE;
        endcase

        // Halt beats branch; both are only looked at in the commit cycle.
        if (take_next) begin
            if (bus.Halt) begin
                state_d = FS_DONE;
            end else if (bus.Jump || (bus.BranchEn && bus.BranchAccept)) begin
                pc_d = lut_rdata;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    assign bus.ProgCtr = pc_q;
    assign bus.Commit  = commit;
    assign bus.Busy    = (state_q == FS_RUN) || (state_q == FS_MEMWAIT);
    assign bus.Done    = (state_q == FS_DONE);

`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
    logic [15:0] cyc_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc_q <= '0;
        end else if (((state_q == FS_IDLE) || (state_q == FS_DONE)) && bus.Start) begin
            cyc_q <= '0;
        end else if (bus.Busy && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign CycleCount = cyc_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer built with MEM_LAT=2, PC_W=10, LUT_IDX_W=4.
module tb_fetch_sequencer;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   ncommit;

    always #5 Clk = ~Clk;

    fetch_sequencer_if #(.PC_W(10), .LUT_IDX_W(4)) bus();

`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
    logic [15:0] CycleCount;
    fetch_sequencer #(.PC_W(10), .LUT_IDX_W(4), .MEM_LAT(2)) dut (
        .Clk(Clk), .Reset(Reset), .CycleCount(CycleCount), .bus(bus));
`else
    fetch_sequencer #(.PC_W(10), .LUT_IDX_W(4), .MEM_LAT(2)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clr_ctl();
        bus.Start = 0; bus.Jump = 0; bus.BranchEn = 0; bus.BranchAccept = 0;
        bus.MemAccess = 0; bus.Halt = 0; bus.LutWe = 0;
    endtask

    task automatic lut_wr(input logic [3:0] a, input logic [9:0] d);
        bus.LutWe = 1; bus.LutWaddr = a; bus.LutWdata = d;
        tick();
        bus.LutWe = 0;
    endtask

    initial begin
        clr_ctl();
        bus.StartAddr = '0; bus.BranchIdx = '0; bus.LutWaddr = '0; bus.LutWdata = '0;
        @(negedge Clk); #1;
        chk("rst_pc", bus.ProgCtr, 0);
        chk("rst_commit", bus.Commit, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
        chk("rst_cyc", CycleCount, 0);
`endif
        Reset = 0;
        @(negedge Clk);

        lut_wr(4'd3, 10'h120);
        lut_wr(4'd2, 10'd10);
        lut_wr(4'd7, 10'h040);
        lut_wr(4'd4, 10'd20);
        bus.Halt = 1; bus.Jump = 1; #1;
        chk("idle_ignore_commit", bus.Commit, 0);
        tick();
        chk("idle_ignore_pc", bus.ProgCtr, 0);
        chk("idle_ignore_done", bus.Done, 0);
        clr_ctl();

        // sequential fetch from 5
        bus.Start = 1; bus.StartAddr = 10'd5;
        tick();
        bus.Start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("seq_pc", bus.ProgCtr, 5 + i);
            chk("seq_commit", bus.Commit, 1);
            chk("seq_busy", bus.Busy, 1);
`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
            chk("seq_cyc", CycleCount, i);
`endif
            tick();
        end
        chk("seq_pc_end", bus.ProgCtr, 9);

        // conditional branch taken / not taken
        bus.BranchEn = 1; bus.BranchAccept = 1; bus.BranchIdx = 4'd3;
        tick();
        chk("br_taken", bus.ProgCtr, 10'h120);
        bus.BranchAccept = 0;
        tick();
        chk("br_not_taken", bus.ProgCtr, 10'h121);
        clr_ctl();

        // Start in RUN is ignored
        bus.Start = 1; bus.StartAddr = 10'h3FE;
        tick();
        bus.Start = 0;
        chk("start_in_run", bus.ProgCtr, 10'h122);

        // memory stall at PC=10
        bus.Jump = 1; bus.BranchIdx = 4'd2;
        tick();
        bus.Jump = 0;
        chk("jump_to_10", bus.ProgCtr, 10);
        bus.MemAccess = 1; #1;
        chk("mem_c0", bus.Commit, 0);
        tick();
        chk("mem_pc1", bus.ProgCtr, 10);
        chk("mem_c1", bus.Commit, 0);
        chk("mem_busy", bus.Busy, 1);
        tick();
        chk("mem_pc2", bus.ProgCtr, 10);
        chk("mem_c2", bus.Commit, 1);
        tick();
        bus.MemAccess = 0;
        chk("mem_pc_next", bus.ProgCtr, 11);

        // memory + jump: one commit, then LUT target
        bus.MemAccess = 1; bus.Jump = 1; bus.BranchIdx = 4'd7;
        ncommit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memj_pc_held", bus.ProgCtr, 11);
            if (bus.Commit) ncommit++;
            tick();
        end
        chk("memj_commits", ncommit, 1);
        chk("memj_target", bus.ProgCtr, 10'h040);
        clr_ctl();

        // halt beats jump at PC=20
        bus.Jump = 1; bus.BranchIdx = 4'd4;
        tick();
        chk("jump_to_20", bus.ProgCtr, 20);
        bus.Halt = 1; bus.BranchIdx = 4'd7; #1;
        chk("halt_commit", bus.Commit, 1);
        tick();
        clr_ctl(); #1;
        chk("halt_done", bus.Done, 1);
        chk("halt_pc", bus.ProgCtr, 20);
        chk("halt_busy", bus.Busy, 0);
        chk("halt_nocommit", bus.Commit, 0);
        tick();
        chk("halt_pc_hold", bus.ProgCtr, 20);
        bus.Start = 1; bus.StartAddr = 10'd0;
        tick();
        bus.Start = 0;
        chk("restart_pc", bus.ProgCtr, 0);
        chk("restart_done", bus.Done, 0);

        // LUT write and same-index read in one cycle returns old value
        bus.LutWe = 1; bus.LutWaddr = 4'd3; bus.LutWdata = 10'h155;
        bus.BranchEn = 1; bus.BranchAccept = 1; bus.BranchIdx = 4'd3;
        tick();
        bus.LutWe = 0;
        chk("lut_old", bus.ProgCtr, 10'h120);
        tick();
        chk("lut_new", bus.ProgCtr, 10'h155);
        clr_ctl();

        // wrap at top of PC space
        bus.Halt = 1;
        tick();
        bus.Halt = 0;
        bus.Start = 1; bus.StartAddr = 10'h3FE;
        tick();
        bus.Start = 0;
        chk("wrap0", bus.ProgCtr, 10'h3FE);
        tick();
        chk("wrap1", bus.ProgCtr, 10'h3FF);
        tick();
        chk("wrap2", bus.ProgCtr, 10'h000);

        // reset in the middle of a stall
        bus.MemAccess = 1;
        tick();
        chk("pre_rst_pc", bus.ProgCtr, 0);
        bus.StartAddr = 10'd9; bus.Jump = 1; bus.BranchIdx = 4'd7;
        tick();
        Reset = 1; #1;
        chk("mid_rst_pc", bus.ProgCtr, 0);
        chk("mid_rst_busy", bus.Busy, 0);
        chk("mid_rst_commit", bus.Commit, 0);
`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
        chk("mid_rst_cyc", CycleCount, 0);
`endif
        clr_ctl();
        @(negedge Clk);
        Reset = 0;
        tick();
        chk("post_rst_idle", bus.Busy, 0);
        bus.Start = 1;
        tick();
        bus.Start = 0;
        chk("post_rst_start", bus.ProgCtr, 9);
        bus.Jump = 1; bus.BranchIdx = 4'd7;
        tick();
        chk("lut_cleared", bus.ProgCtr, 0);
        clr_ctl();

`ifdef FETCH_SEQUENCER_CYCLE_COUNT_EN
        for (int i = 0; i < 70000; i++) @(posedge Clk);
        @(negedge Clk);
        chk("cyc_sat", CycleCount, 16'hFFFF);
        bus.Halt = 1;
        tick();
        bus.Halt = 0;
        tick();
        chk("cyc_hold_done", CycleCount, 16'hFFFF);
        bus.Start = 1;
        tick();
        bus.Start = 0;
        chk("cyc_start_clr", CycleCount, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
